// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - lsu_state_e : controller states (IDLE, ACCESS, RESP)
//   - LB..LWU     : RISC-V load funct3 encodings. Stores reuse the low codes:
//                   SB=LB, SH=LH, SW=LW, SD=LD.
//   - lsu_is_illegal : flags a funct3 that the unit rejects without touching memory
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // 111 has no meaning for loads or stores. Stores have no unsigned
    // variants, so any store with funct3[2] set is also rejected.
    function automatic logic lsu_is_illegal(input logic we, input logic [2:0] funct3);
        return (funct3 == 3'b111) || (we && funct3[2]);
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store sequencer between a request/response pipeline
// and a word-addressed memory with combinational, already-extended read data.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we, req_addr,
//   req_funct3, req_wdata,
//   req_rd                   request fields, registered on acceptance
//   resp_valid / resp_ready  response handshake
//   resp_data, resp_rd,
//   resp_err                 load data (0 for stores/errors), echoed tag, illegal flag
//   mem_we, mem_address,
//   mem_mode, mem_wdata      memory drive (mode = funct3)
//   mem_rdata                memory read data
//   load_count, store_count  completed access counters (wrap at 2^32)
//
// Timing: legal request accepted at edge N -> ACCESS cycle -> response valid
// from cycle N+2. Illegal request skips ACCESS, response valid from N+1.
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_BITS  = 20,
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [MEM_BITS-1:0]  req_addr,
    input  logic [2:0]           req_funct3,
    input  logic [DATA_SIZE-1:0] req_wdata,
    input  logic [4:0]           req_rd,

    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_SIZE-1:0] resp_data,
    output logic [4:0]           resp_rd,
    output logic                 resp_err,

    output logic                 mem_we,
    output logic [MEM_BITS-1:0]  mem_address,
    output logic [2:0]           mem_mode,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,

    output logic [31:0]          load_count,
    output logic [31:0]          store_count
);
    import lsu_pkg::*;

    lsu_state_e           r_state;

    logic                 r_we;
    logic [MEM_BITS-1:0]  r_addr;
    logic [2:0]           r_funct3;
    logic [DATA_SIZE-1:0] r_wdata;

    logic [DATA_SIZE-1:0] r_resp_data;
    logic [4:0]           r_resp_rd;
    logic                 r_resp_err;

    logic [31:0]          r_load_count;
    logic [31:0]          r_store_count;

    logic                 w_illegal;

    assign w_illegal = lsu_is_illegal(req_we, req_funct3);

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_rd    = r_resp_rd;
    assign resp_err   = r_resp_err;

    // The memory port is driven straight from the registered request, so it
    // holds the last accepted request outside ACCESS; only the write enable
    // is qualified by the state.
    assign mem_we      = (r_state == ST_ACCESS) && r_we;
    assign mem_address = r_addr;
    assign mem_mode    = r_funct3;
    assign mem_wdata   = r_wdata;

    assign load_count  = r_load_count;
    assign store_count = r_store_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_funct3      <= '0;
            r_wdata       <= '0;
            r_resp_data   <= '0;
            r_resp_rd     <= '0;
            r_resp_err    <= 1'b0;
            r_load_count  <= '0;
            r_store_count <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_addr    <= req_addr;
                        r_funct3  <= req_funct3;
                        r_wdata   <= req_wdata;
                        r_resp_rd <= req_rd;
                        if (w_illegal) begin
                            // Rejected requests answer immediately with no access.
                            r_resp_err  <= 1'b1;
                            r_resp_data <= '0;
                            r_state     <= ST_RESP;
                        end else begin
                            r_resp_err  <= 1'b0;
                            r_state     <= ST_ACCESS;
                        end
                    end
                end

                ST_ACCESS: begin
                    r_resp_data <= r_we ? '0 : mem_rdata;
                    if (r_we) begin
                        r_store_count <= r_store_count + 32'd1;
                    end else begin
                        r_load_count  <= r_load_count + 32'd1;
                    end
                    r_state <= ST_RESP;
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed plus randomized bench for load_store_unit. A behavioural memory
// answers the DUT's memory port; an independent reference memory and
// expected counters are updated from each request's own fields.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int MEM_BITS  = 20;
    localparam int DATA_SIZE = 64;

    logic                 clk;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [MEM_BITS-1:0]  req_addr;
    logic [2:0]           req_funct3;
    logic [DATA_SIZE-1:0] req_wdata;
    logic [4:0]           req_rd;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DATA_SIZE-1:0] resp_data;
    logic [4:0]           resp_rd;
    logic                 resp_err;
    logic                 mem_we;
    logic [MEM_BITS-1:0]  mem_address;
    logic [2:0]           mem_mode;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;
    logic [31:0]          load_count;
    logic [31:0]          store_count;

    int vectors     = 0;
    int miscompares = 0;

    load_store_unit #(.MEM_BITS(MEM_BITS), .DATA_SIZE(DATA_SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_funct3  (req_funct3),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_rd     (resp_rd),
        .resp_err    (resp_err),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_mode    (mem_mode),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .load_count  (load_count),
        .store_count (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sign/zero extension of the low 1/2/4/8 bytes selected by funct3.
    function automatic logic [63:0] ext(input logic [63:0] w, input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return f3[2] ? {56'd0, w[7:0]}  : {{56{w[7]}},  w[7:0]};
            2'd1:    return f3[2] ? {48'd0, w[15:0]} : {{48{w[15]}}, w[15:0]};
            2'd2:    return f3[2] ? {32'd0, w[31:0]} : {{32{w[31]}}, w[31:0]};
            default: return w;
        endcase
    endfunction

    // Store of 1/2/4/8 bytes into the low end of a word.
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [2:0] f3);
        logic [63:0] m;
        m = (f3[1:0] == 2'd3) ? 64'hFFFF_FFFF_FFFF_FFFF
                              : ((64'd1 << (8 << f3[1:0])) - 64'd1);
        return (old & ~m) | (wd & m);
    endfunction

    // Behavioural memory answering the DUT's memory port.
    logic [63:0] mem [256];
    logic        mem_clr;
    int          we_pulses = 0;

    assign mem_rdata = ext(mem[mem_address[7:0]], mem_mode);

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_address[7:0]] <= merge(mem[mem_address[7:0]], mem_wdata, mem_mode);
            we_pulses <= we_pulses + 1;
        end
    end

    // Reference state.
    logic [63:0] refmem [256];
    logic [31:0] exp_ld;
    logic [31:0] exp_st;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request through to its response handshake. hold = cycles with
    // resp_ready low; intrude = offer an illegal request (rd 1F) during the
    // hold and leave it asserted on return.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [19:0] addr,
                          input logic [63:0] wd, input logic [4:0] rd, input int hold,
                          input bit intrude, output logic [63:0] got);
        bit          ill;
        logic [63:0] exp_data;
        int          p0;
        ill      = (f3 == 3'b111) || (we && f3[2]);
        exp_data = (we || ill) ? 64'd0 : ext(refmem[addr[7:0]], f3);
        p0       = we_pulses;

        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        req_rd     = rd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_wdata  = ~wd;

        if (!ill) begin
            chk("resp_valid_access", {63'd0, resp_valid}, 64'd0);
            chk("req_ready_access",  {63'd0, req_ready},  64'd0);
            chk("mem_we_access",     {63'd0, mem_we},     {63'd0, we});
            chk("mem_address",       {44'd0, mem_address}, {44'd0, addr});
            chk("mem_mode",          {61'd0, mem_mode},    {61'd0, f3});
            if (we) chk("mem_wdata", mem_wdata, wd);
            @(posedge clk); #1;
        end

        chk("resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("resp_err",   {63'd0, resp_err},   {63'd0, ill});
        chk("resp_data",  resp_data, exp_data);
        chk("resp_rd",    {59'd0, resp_rd},    {59'd0, rd});
        chk("req_ready_resp", {63'd0, req_ready}, 64'd0);
        got = resp_data;

        if (!ill) begin
            if (we) begin
                refmem[addr[7:0]] = merge(refmem[addr[7:0]], wd, f3);
                exp_st = exp_st + 32'd1;
            end else begin
                exp_ld = exp_ld + 32'd1;
            end
        end

        if (intrude) begin
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'b111;
            req_rd     = 5'h1F;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_resp_data",  resp_data, exp_data);
            chk("hold_resp_rd",    {59'd0, resp_rd}, {59'd0, rd});
            chk("hold_req_ready",  {63'd0, req_ready}, 64'd0);
        end

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_after", {63'd0, resp_valid}, 64'd0);
        chk("req_ready_after",  {63'd0, req_ready},  64'd1);
        chk("load_count",  {32'd0, load_count},  {32'd0, exp_ld});
        chk("store_count", {32'd0, store_count}, {32'd0, exp_st});
        chk("mem_we_pulses", 64'(we_pulses - p0), {63'd0, (we && !ill)});
    endtask

    initial begin
        logic [63:0] got;
        logic [2:0]  f3;
        logic        we;

        rst        = 1'b1;
        mem_clr    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        req_wdata  = '0;
        req_rd     = '0;
        resp_ready = 1'b0;
        exp_ld     = '0;
        exp_st     = '0;
        for (int i = 0; i < 256; i++) refmem[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Reset state
        chk("rst_req_ready",   {63'd0, req_ready},  64'd1);
        chk("rst_mem_we",      {63'd0, mem_we},     64'd0);
        chk("rst_resp_valid",  {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_err",    {63'd0, resp_err},   64'd0);
        chk("rst_resp_data",   resp_data, 64'd0);
        chk("rst_resp_rd",     {59'd0, resp_rd},    64'd0);
        chk("rst_load_count",  {32'd0, load_count},  64'd0);
        chk("rst_store_count", {32'd0, store_count}, 64'd0);
        chk("rst_mem_address", {44'd0, mem_address}, 64'd0);

        // SD 0x1122334455667788 to 0x10
        do_req(1'b1, 3'b011, 20'h10, 64'h1122_3344_5566_7788, 5'd3, 0, 1'b0, got);
        chk("sd_store_count", {32'd0, store_count}, 64'd1);

        // LB from 0x10: low byte 0x88 sign-extends
        do_req(1'b0, 3'b000, 20'h10, 64'd0, 5'd7, 0, 1'b0, got);
        chk("lb_value", got, 64'hFFFF_FFFF_FFFF_FF88);
        chk("lb_load_count", {32'd0, load_count}, 64'd1);

        // Illegal load funct3 = 111: one-cycle error response
        do_req(1'b0, 3'b111, 20'h20, 64'd0, 5'd9, 0, 1'b0, got);
        // Illegal store funct3[2] = 1
        do_req(1'b1, 3'b100, 20'h21, 64'hDEAD_BEEF, 5'd10, 1, 1'b0, got);

        // Back-pressure for 5 cycles with a competing request held high,
        // which is accepted only after the handshake.
        do_req(1'b0, 3'b010, 20'h10, 64'd0, 5'd12, 5, 1'b1, got);
        do_req(1'b0, 3'b111, 20'h0, 64'd0, 5'h1F, 0, 1'b0, got);

        // Reset while a load response is pending
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 20'h10;
        req_funct3 = 3'b011;
        req_rd     = 5'd4;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_resp_valid", {63'd0, resp_valid}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ld = '0;
        exp_st = '0;
        chk("mid_rst_resp_valid",  {63'd0, resp_valid}, 64'd0);
        chk("mid_rst_req_ready",   {63'd0, req_ready},  64'd1);
        chk("mid_rst_load_count",  {32'd0, load_count},  64'd0);
        chk("mid_rst_store_count", {32'd0, store_count}, 64'd0);
        chk("mid_rst_resp_data",   resp_data, 64'd0);

        // Store counter wrap
        @(negedge clk);
        force dut.r_store_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.r_store_count;
        exp_st = 32'hFFFF_FFFF;
        chk("preload_store_count", {32'd0, store_count}, 64'h0000_0000_FFFF_FFFF);
        do_req(1'b1, 3'b000, 20'h33, 64'h55, 5'd2, 0, 1'b0, got);
        chk("wrap_store_count", {32'd0, store_count}, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            do_req(we, f3, 20'($urandom_range(0, 255)), {$urandom, $urandom},
                   5'($urandom_range(0, 31)), $urandom_range(0, 2), 1'b0, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BITS, default 20, SHALL set the word-address width of the memory port.
REQ-002 Parameter DATA_SIZE, default 64, SHALL set the data width.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL change on posedge clk.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL mean a request is offered.
REQ-006 req_ready  out  1  SHALL mean the unit accepts a request this cycle.
REQ-007 req_we  in  1  SHALL select store (1) or load (0).
REQ-008 req_addr  in  MEM_BITS  SHALL be the word address.
REQ-009 req_funct3  in  3  SHALL be the RISC-V load/store funct3.
REQ-010 req_wdata  in  DATA_SIZE  SHALL be the store data.
REQ-011 req_rd  in  5  SHALL be the destination-register tag, returned unchanged.
REQ-012 resp_valid  out  1  SHALL mean a response is presented.
REQ-013 resp_ready  in  1  SHALL mean the consumer takes the response.
REQ-014 resp_data  out  DATA_SIZE  SHALL be the extended load data (0 for stores and errors).
REQ-015 resp_rd  out  5  SHALL be the request tag.
REQ-016 resp_err  out  1  SHALL flag an illegal funct3.
REQ-017 mem_we, mem_address (MEM_BITS), mem_mode (3), mem_wdata (DATA_SIZE)  out SHALL drive the memory write enable, word address, access mode and write data.
REQ-018 mem_rdata  in  DATA_SIZE  SHALL be the memory's combinational, already-extended read data.
REQ-019 load_count, store_count  out  32 each SHALL count completed memory accesses.

Function
REQ-020 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1, and all req_* fields SHALL be registered at that edge.
REQ-022 A legal request SHALL move IDLE -> ACCESS; in the ACCESS cycle mem_address, mem_mode and mem_wdata SHALL come from the registered request.
REQ-023 mem_we SHALL be 1 only in an ACCESS cycle of a store, for exactly one cycle per store.
REQ-024 For a load, mem_rdata SHALL be captured into resp_data at the end of ACCESS; for a store, resp_data SHALL be 0.
REQ-025 ACCESS SHALL always move to RESP; resp_valid SHALL be 1 only in RESP and SHALL hold with stable data until resp_ready is 1, then the FSM SHALL move to IDLE.
REQ-026 Latency: a request accepted at edge N SHALL produce resp_valid from cycle N+2; the next request SHALL be acceptable at the earliest one cycle after the response handshake.
REQ-027 funct3 = 111, or a store with funct3[2] = 1, SHALL be illegal: IDLE -> RESP directly, no memory access, resp_err = 1, resp_data = 0, latency 1.
REQ-028 Outside ACCESS, mem_address, mem_mode and mem_wdata SHALL hold their last registered values.
REQ-029 The ACCESS exit edge of a legal load or store SHALL increment load_count or store_count respectively, wrapping modulo 2^32; errors SHALL not count.
REQ-030 req_valid arriving while the unit is busy SHALL be ignored until IDLE (req_ready = 0); the producer holds it.

Reset
REQ-031 When rst is 1 at a posedge, the unit SHALL enter IDLE and clear resp_valid, resp_err, resp_data, resp_rd, load_count, store_count and all registered request fields.
REQ-032 After reset, req_ready SHALL be 1 and mem_we 0.
REQ-033 If rst is asserted during a store's ACCESS cycle, that store's write at the same edge MAY complete, and it SHALL not be counted; any pending response SHALL be discarded.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum and the funct3 constants LB, LH, LW, LD, LBU, LHU, LWU.
REQ-035 The block SHALL be a single module with no sub-modules; the memory-port signal names SHALL mirror the memory block's port semantics.

Verification
REQ-036 Store funct3 = 011, address 0x10, data 0x1122334455667788 -> exactly one mem_we pulse with matching ports, resp_valid at N+2 with resp_data = 0, store_count = 1.
REQ-037 Load funct3 = 000 at 0x10 with the memory model returning 0xFFFFFFFFFFFFFF88 -> resp_data = 0xFFFFFFFFFFFFFF88, resp_rd echoed, load_count = 1.
REQ-038 Load funct3 = 111 -> resp_valid at N+1, resp_err = 1, mem_we never asserted, counters unchanged.
REQ-039 resp_ready held at 0 for 5 cycles -> resp_valid and resp_data stable throughout, req_ready = 0, a second req_valid is not accepted until after the handshake.
REQ-040 rst pulsed while in RESP -> next cycle in IDLE, resp_valid = 0, counters = 0, req_ready = 1.
REQ-041 Preload store_count = 0xFFFFFFFF, then one store -> store_count wraps to 0.
